// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the runtime-programmable serial pattern detector.
package seq_det_pkg;

   localparam int unsigned SEQ_MAX_LEN = 8;
   localparam int unsigned LEN_W       = $clog2(SEQ_MAX_LEN + 1);
   localparam int unsigned MASK_W      = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      DETECT = 2'd2
   } state_e;

   // Low 'len' bits set; callers narrow the result to their own pattern width.
   function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
      logic [MASK_W-1:0] m;
      if (len >= MASK_W) begin
         m = '1;
      end else begin
         m = (MASK_W'(1) << len) - MASK_W'(1);
      end
      return m;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with runtime pattern/length/overlap and a saturating
// match tally. Oldest pattern bit sits at pat[len-1], newest at pat[0].
module seq_pattern_detector
   import seq_det_pkg::*;
#(
   parameter int unsigned MAX_LEN = 8,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           cfg_we,
   input  logic [MAX_LEN-1:0]             cfg_pattern,
   input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
   input  logic                           cfg_overlap,
   input  logic                           in_valid,
   input  logic                           in_bit,
   input  logic                           clr_count,
   output logic                           match,
   output logic [CNT_W-1:0]               match_count,
   output logic                           armed,
   output logic                           cfg_err
);

   localparam int unsigned CFG_LEN_W = $clog2(MAX_LEN + 1);

   state_e                 state_q, state_d;
   logic [MAX_LEN-1:0]     hist_q, hist_d;
   logic [CFG_LEN_W-1:0]   fill_q, fill_d;
   logic [MAX_LEN-1:0]     pat_q, pat_d;
   logic [CFG_LEN_W-1:0]   len_q, len_d;
   logic                   ovl_q, ovl_d;
   logic                   match_q, match_d;
   logic                   cfg_err_q, cfg_err_d;
   logic                   armed_q;

   logic                   cfg_legal_c;
   logic [MAX_LEN-1:0]     hist_n_c;
   logic [CFG_LEN_W-1:0]   fill_n_c;
   logic [MAX_LEN-1:0]     mask_c;
   logic                   hit_c;

   assign cfg_legal_c = (cfg_len != '0) && (cfg_len <= CFG_LEN_W'(MAX_LEN));
   assign hist_n_c    = MAX_LEN'({hist_q, in_bit});
   assign fill_n_c    = (fill_q == CFG_LEN_W'(MAX_LEN)) ? fill_q : fill_q + CFG_LEN_W'(1);
   assign mask_c      = MAX_LEN'(len_mask(32'(len_q)));

   // Next-state, datapath and output decode.
   always_comb begin
      state_d   = state_q;
      hist_d    = hist_q;
      fill_d    = fill_q;
      pat_d     = pat_q;
      len_d     = len_q;
      ovl_d     = ovl_q;
      match_d   = 1'b0;
      cfg_err_d = 1'b0;
      hit_c     = 1'b0;

      if (cfg_we) begin
         hist_d = '0;
         fill_d = '0;
         if (cfg_legal_c) begin
            pat_d   = cfg_pattern;
            len_d   = cfg_len;
            ovl_d   = cfg_overlap;
            state_d = FILL;
         end else begin
            pat_d     = '0;
            len_d     = '0;
            ovl_d     = 1'b0;
            cfg_err_d = 1'b1;
            state_d   = IDLE;
         end
      end else if (in_valid && (state_q != IDLE)) begin
         hist_d = hist_n_c;
         fill_d = fill_n_c;
         hit_c  = (fill_n_c >= len_q) && (((hist_n_c ^ pat_q) & mask_c) == '0);
         if (hit_c) begin
            match_d = 1'b1;
            if (ovl_q) begin
               state_d = DETECT;
            end else begin
               // Non-overlap: matched bits must not count toward the next hit.
               fill_d  = '0;
               state_d = FILL;
            end
         end else if (fill_n_c >= len_q) begin
            state_d = DETECT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         hist_q    <= '0;
         fill_q    <= '0;
         pat_q     <= '0;
         len_q     <= '0;
         ovl_q     <= 1'b0;
         match_q   <= 1'b0;
         cfg_err_q <= 1'b0;
         armed_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         pat_q     <= pat_d;
         len_q     <= len_d;
         ovl_q     <= ovl_d;
         match_q   <= match_d;
         cfg_err_q <= cfg_err_d;
         armed_q   <= (state_d != IDLE);
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_match_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_count),
      .inc   (hit_c),
      .count (match_count)
   );

   assign match   = match_q;
   assign armed   = armed_q;
   assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Self-checking bench: directed vector table, hand-written corner sequences and a
// randomized run against a queue-based reference model.
module tb_seq_pattern_detector;

   logic        clk;
   logic        reset;
   logic        cfg_we;
   logic [7:0]  cfg_pattern;
   logic [3:0]  cfg_len;
   logic        cfg_overlap;
   logic        in_valid;
   logic        in_bit;
   logic        clr_count;

   logic        match;
   logic [15:0] match_count;
   logic        armed;
   logic        cfg_err;

   logic        match2;
   logic [1:0]  match_count2;
   logic        armed2;
   logic        cfg_err2;

   int n_tests = 0;
   int n_fail  = 0;

   seq_pattern_detector #(.MAX_LEN(8), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
      .in_bit(in_bit), .clr_count(clr_count), .match(match),
      .match_count(match_count), .armed(armed), .cfg_err(cfg_err)
   );

   // Narrow-counter instance sharing the same stimulus, used for saturation.
   seq_pattern_detector #(.MAX_LEN(8), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
      .in_bit(in_bit), .clr_count(clr_count), .match(match2),
      .match_count(match_count2), .armed(armed2), .cfg_err(cfg_err2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: bits accepted since the last (re)start, newest at the back.
   bit         m_armed = 1'b0;
   int         m_len   = 0;
   logic [7:0] m_pat   = '0;
   bit         m_ovl   = 1'b0;
   bit         m_win[$];
   int         m_cnt   = 0;
   int         m_cnt2  = 0;
   bit         e_match = 1'b0;
   bit         e_err   = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_update(input bit r, input bit we, input logic [7:0] p,
                               input logic [3:0] l, input bit o, input bit v,
                               input bit b, input bit clr);
      bit hit;
      hit     = 1'b0;
      e_match = 1'b0;
      e_err   = 1'b0;
      if (r) begin
         m_armed = 1'b0; m_len = 0; m_pat = '0; m_ovl = 1'b0;
         m_win.delete(); m_cnt = 0; m_cnt2 = 0;
         return;
      end
      if (we) begin
         m_win.delete();
         if (l >= 1 && l <= 8) begin
            m_armed = 1'b1; m_len = int'(l); m_pat = p; m_ovl = o;
         end else begin
            m_armed = 1'b0; m_len = 0; m_pat = '0; m_ovl = 1'b0; e_err = 1'b1;
         end
      end else if (v && m_armed) begin
         m_win.push_back(b);
         if (m_win.size() > 8) void'(m_win.pop_front());
         if (m_win.size() >= m_len) begin
            hit = 1'b1;
            for (int k = 0; k < m_len; k++)
               if (m_win[m_win.size() - 1 - k] != m_pat[k]) hit = 1'b0;
         end
         if (hit) begin
            e_match = 1'b1;
            if (!m_ovl) m_win.delete();
         end
      end
      if (clr) begin
         m_cnt = 0; m_cnt2 = 0;
      end else if (hit) begin
         m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : m_cnt;
         m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
      end
   endtask

   // One clock: drive on the falling edge, check model 1 time unit after the rising edge.
   task automatic step(input bit r, input bit we, input logic [7:0] p,
                       input logic [3:0] l, input bit o, input bit v,
                       input bit b, input bit clr);
      @(negedge clk);
      reset = r; cfg_we = we; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
      in_valid = v; in_bit = b; clr_count = clr;
      model_update(r, we, p, l, o, v, b, clr);
      @(posedge clk);
      #1;
      chk("match",        int'(match),        int'(e_match));
      chk("match_count",  int'(match_count),  m_cnt);
      chk("armed",        int'(armed),        int'(m_armed));
      chk("cfg_err",      int'(cfg_err),      int'(e_err));
      chk("match_count2", int'(match_count2), m_cnt2);
   endtask

   task automatic idle();
      step(0, 0, 8'h00, 4'd0, 0, 0, 0, 0);
   endtask

   task automatic bit_in(input bit b);
      step(0, 0, 8'h00, 4'd0, 0, 1, b, 0);
   endtask

   typedef struct {
      bit         rst;
      bit         we;
      logic [7:0] pat;
      logic [3:0] len;
      bit         ovl;
      bit         v;
      bit         b;
      bit         clr;
      bit         em;
      int         ec;
      bit         ea;
      bit         ee;
   } vec_t;

   function automatic vec_t mk(bit rst, bit we, logic [7:0] pat, logic [3:0] len,
                               bit ovl, bit v, bit b, bit clr,
                               bit em, int ec, bit ea, bit ee);
      vec_t t;
      t.rst = rst; t.we = we; t.pat = pat; t.len = len; t.ovl = ovl;
      t.v = v; t.b = b; t.clr = clr; t.em = em; t.ec = ec; t.ea = ea; t.ee = ee;
      return t;
   endfunction

   vec_t tbl[$];

   initial begin
      int hits;
      bit prev_m, contig;
      int r;
      logic [3:0] rl;

      reset = 1'b1; cfg_we = 0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
      in_valid = 0; in_bit = 0; clr_count = 0;

      // Overlap run, clear, then non-overlap run of the same stream.
      tbl.push_back(mk(1,0,8'h00,4'd0,0,0,0,0, 0,0,0,0));
      tbl.push_back(mk(0,1,8'h0D,4'd4,1,0,0,0, 0,0,1,0));
      tbl.push_back(mk(0,0,8'h00,4'd0,0,1,1,0, 0,0,1,0));
      tbl.push_back(mk(0,0,8'h00,4'd0,0,1,1,0, 0,0,1,0));
      tbl.push_back(mk(0,0,8'h00,4'd0,0,1,0,0, 0,0,1,0));
      tbl.push_back(mk(0,0,8'h00,4'd0,0,1,1,0, 1,1,1,0));
      tbl.push_back(mk(0,0,8'h00,4'd0,0,1,1,0, 0,1,1,0));
      tbl.push_back(mk(0,0,8'h00,4'd0,0,1,0,0, 0,1,1,0));
      tbl.push_back(mk(0,0,8'h00,4'd0,0,1,1,0, 1,2,1,0));
      tbl.push_back(mk(0,0,8'h00,4'd0,0,0,0,1, 0,0,1,0));
      tbl.push_back(mk(0,1,8'h0D,4'd4,0,0,0,0, 0,0,1,0));
      tbl.push_back(mk(0,0,8'h00,4'd0,0,1,1,0, 0,0,1,0));
      tbl.push_back(mk(0,0,8'h00,4'd0,0,1,1,0, 0,0,1,0));
      tbl.push_back(mk(0,0,8'h00,4'd0,0,1,0,0, 0,0,1,0));
      tbl.push_back(mk(0,0,8'h00,4'd0,0,1,1,0, 1,1,1,0));
      tbl.push_back(mk(0,0,8'h00,4'd0,0,1,1,0, 0,1,1,0));
      tbl.push_back(mk(0,0,8'h00,4'd0,0,1,0,0, 0,1,1,0));
      tbl.push_back(mk(0,0,8'h00,4'd0,0,1,1,0, 0,1,1,0));

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].we, tbl[i].pat, tbl[i].len, tbl[i].ovl,
              tbl[i].v, tbl[i].b, tbl[i].clr);
         chk($sformatf("tbl%0d_match", i), int'(match),       int'(tbl[i].em));
         chk($sformatf("tbl%0d_count", i), int'(match_count), tbl[i].ec);
         chk($sformatf("tbl%0d_armed", i), int'(armed),       int'(tbl[i].ea));
         chk($sformatf("tbl%0d_err",   i), int'(cfg_err),     int'(tbl[i].ee));
      end

      // len=1 overlap: 1,1,0,1 gives three hits, first two back-to-back.
      step(1, 0, 8'h00, 4'd0, 0, 0, 0, 0);
      step(0, 1, 8'h01, 4'd1, 1, 0, 0, 0);
      hits = 0; prev_m = 0; contig = 0;
      for (int i = 0; i < 4; i++) begin
         bit_in((i == 2) ? 1'b0 : 1'b1);
         if (match) hits++;
         if (i == 1 && match && prev_m) contig = 1;
         prev_m = match;
      end
      chk("len1_hits", hits, 3);
      chk("len1_contig", int'(contig), 1);
      for (int i = 0; i < 10; i++) bit_in(1'b1);
      chk("sat_cnt2", int'(match_count2), 3);

      // Illegal lengths: error pulse, disarmed, stream ignored.
      step(0, 1, 8'hFF, 4'd0, 1, 0, 0, 0);
      chk("len0_err", int'(cfg_err), 1);
      chk("len0_armed", int'(armed), 0);
      idle();
      chk("err_one_cycle", int'(cfg_err), 0);
      for (int i = 0; i < 4; i++) bit_in(1'b1);
      step(0, 1, 8'hFF, 4'd9, 1, 0, 0, 0);
      chk("len9_err", int'(cfg_err), 1);
      chk("len9_armed", int'(armed), 0);
      for (int i = 0; i < 4; i++) bit_in(1'b1);

      // Idle gaps keep partial progress.
      step(0, 1, 8'h05, 4'd3, 1, 0, 0, 0);
      bit_in(1); bit_in(0);
      for (int i = 0; i < 5; i++) idle();
      bit_in(1);
      chk("gap_match", int'(match), 1);

      // Reset mid-stream discards 1,1,0 of 1101.
      step(0, 1, 8'h0D, 4'd4, 0, 0, 0, 0);
      bit_in(1); bit_in(1); bit_in(0);
      step(1, 0, 8'h00, 4'd0, 0, 0, 0, 0);
      step(0, 1, 8'h0D, 4'd4, 0, 0, 0, 0);
      bit_in(1);
      chk("rst_no_match", int'(match), 0);

      // Bit presented with cfg_we is dropped.
      step(0, 1, 8'h01, 4'd1, 1, 1, 1, 0);
      idle();
      chk("cfg_drop_bit", int'(match), 0);

      // Clear coincident with a hit.
      bit_in(1);
      step(0, 0, 8'h00, 4'd0, 0, 1, 1, 1);
      chk("clr_hit_match", int'(match), 1);
      chk("clr_hit_count", int'(match_count), 0);

      // Randomized run against the model.
      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 1) begin
            step(1, 0, 8'h00, 4'd0, 0, 0, 0, 0);
         end else if (r < 5) begin
            rl = (r < 4) ? 4'($urandom_range(1, 3)) : 4'($urandom_range(0, 9));
            step(0, 1, 8'($urandom), rl, 1'($urandom), 1'($urandom), 1'($urandom), 0);
         end else begin
            step(0, 0, 8'h00, 4'd0, 0, $urandom_range(0, 3) != 0, 1'($urandom),
                 $urandom_range(0, 49) == 0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
